// File: rtl/tessia_pkg.sv
// Shared Tessia pipeline types: the fetch-queue entry and its default geometry.
package tessia_pkg;

    localparam int FQ_WIDTH  = 32;
    localparam int FQ_ADDR_W = 32;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_AFULL  = 3;
    localparam int FQ_PTR_W  = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [FQ_ADDR_W-1:0] pc;
        logic [FQ_WIDTH-1:0]  instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array for the fetch queue: synchronous write, asynchronous read, no reset.
module fq_storage #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wrEn,
    input  logic [IDX_W-1:0]   wrAddr,
    input  logic [ENTRY_W-1:0] wrData,
    input  logic [IDX_W-1:0]   rdAddr,
    output logic [ENTRY_W-1:0] rdData
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry {PC, instruction} FIFO between fetch and decode with single-cycle flush.
module fetch_queue
    import tessia_pkg::*;
#(
    parameter int WIDTH  = FQ_WIDTH,
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int DEPTH  = FQ_DEPTH,
    parameter int AFULL  = FQ_AFULL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [WIDTH-1:0]         push_instr,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [ADDR_W-1:0]        pop_pc,
    output logic [WIDTH-1:0]         pop_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int PTR_W   = $clog2(DEPTH) + 1;
    localparam int IDX_W   = PTR_W - 1;
    localparam int ENTRY_W = ADDR_W + WIDTH;

    logic [PTR_W-1:0]   rdPtr, wrPtr, rdPtrNext, wrPtrNext;
    logic [PTR_W-1:0]   countNext;
    logic               empty, full, pushFire, popFire;
    logic [ENTRY_W-1:0] headEntry;

    // Wrap bit distinguishes full from empty when the index bits coincide.
    always_comb begin
        empty     = (rdPtr == wrPtr);
        full      = (rdPtr[IDX_W-1:0] == wrPtr[IDX_W-1:0]) && (rdPtr[PTR_W-1] != wrPtr[PTR_W-1]);
        pushFire  = push_valid && !full && !flush;
        popFire   = pop_ready && !empty && !flush;
        rdPtrNext = rdPtr;
        wrPtrNext = wrPtr;
        countNext = count;
        if (flush) begin
            rdPtrNext = '0;
            wrPtrNext = '0;
            countNext = '0;
        end else begin
            if (pushFire) wrPtrNext = wrPtr + PTR_W'(1);
            if (popFire)  rdPtrNext = rdPtr + PTR_W'(1);
            if (pushFire && !popFire) countNext = count + PTR_W'(1);
            else if (!pushFire && popFire) countNext = count - PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtrNext;
            wrPtr <= wrPtrNext;
            count <= countNext;
        end
    end

    fq_storage #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .IDX_W   (IDX_W)
    ) uStorage (
        .clk    (clk),
        .wrEn   (pushFire),
        .wrAddr (wrPtr[IDX_W-1:0]),
        .wrData ({push_pc, push_instr}),
        .rdAddr (rdPtr[IDX_W-1:0]),
        .rdData (headEntry)
    );

    assign push_ready  = !full;
    assign pop_valid   = !empty && !flush;
    assign almost_full = (count >= PTR_W'(AFULL));
    // Storage is unreset, so the head read is masked while reset is held.
    assign pop_pc      = reset ? headEntry[ENTRY_W-1:WIDTH] : '0;
    assign pop_instr   = reset ? headEntry[WIDTH-1:0] : '0;

endmodule
